// File: rtl/byte_arb_pkg.sv
// Shared types and constants for the two-requester byte-packing arbiter.
package byte_arb_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_EMIT    = 2'd2
  } arb_state_t;

  // Width that can hold every value from 0 up to and including bpw.
  function automatic int count_width(input int bpw);
    return $clog2(bpw + 1);
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Shift register that packs bytes MSB-lane first, plus a count of bytes packed.
module byte_packer
  import byte_arb_pkg::*;
#(
  parameter int BYTES_PER_WORD = 4,
  parameter int WORD_W         = BYTE_W * BYTES_PER_WORD,
  parameter int CNT_W          = count_width(BYTES_PER_WORD)
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              load_en,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word_out,
  output logic [CNT_W-1:0]  count_out
);

  logic [WORD_W-1:0] r_word;
  logic [CNT_W-1:0]  r_count;

  always_ff @(posedge clock) begin
    if (clear) begin
      r_word  <= '0;
      r_count <= '0;
    end else if (load_en) begin
      r_word  <= {r_word[WORD_W-BYTE_W-1:0], byte_in};
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign word_out  = r_word;
  assign count_out = r_count;

endmodule

// File: rtl/byte_stream_arbiter.sv
// Round-robin arbiter that locks onto one byte requester until a full word
// has been packed, then presents that word downstream.
module byte_stream_arbiter
  import byte_arb_pkg::*;
#(
  parameter int BYTES_PER_WORD = 4
) (
  input  logic                             clock,
  input  logic                             clear,
  input  logic                             req0_valid,
  input  logic [BYTE_W-1:0]                req0_data,
  output logic                             req0_ready,
  input  logic                             req1_valid,
  input  logic [BYTE_W-1:0]                req1_data,
  output logic                             req1_ready,
  output logic                             word_valid,
  output logic [BYTE_W*BYTES_PER_WORD-1:0] word_data,
  output logic                             word_src,
  input  logic                             word_ready,
  output logic [1:0]                       grant
);

  localparam int WORD_W = BYTE_W * BYTES_PER_WORD;
  localparam int CNT_W  = count_width(BYTES_PER_WORD);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BYTES_PER_WORD - 1);

  arb_state_t        r_state, w_state_nxt;
  logic              r_src, w_src_nxt;
  logic              r_last_winner, w_last_nxt;
  logic              w_load;
  logic              w_word_done;
  logic              w_owner_valid;
  logic [BYTE_W-1:0] w_owner_data;
  logic [CNT_W-1:0]  w_count;
  logic              w_pack_clear;

  assign w_owner_valid = r_src ? req1_valid : req0_valid;
  assign w_owner_data  = r_src ? req1_data  : req0_data;

  always_ff @(posedge clock) begin
    if (clear) begin
      r_state       <= ST_IDLE;
      r_src         <= 1'b0;
      r_last_winner <= 1'b1;
    end else begin
      r_state       <= w_state_nxt;
      r_src         <= w_src_nxt;
      r_last_winner <= w_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_src_nxt   = r_src;
    w_last_nxt  = r_last_winner;
    w_load      = 1'b0;
    w_word_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req0_valid || req1_valid) begin
          // On a tie the requester that did not win last time gets the grant.
          w_src_nxt   = (req0_valid && req1_valid) ? ~r_last_winner : req1_valid;
          w_state_nxt = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (w_owner_valid) begin
          w_load = 1'b1;
          if (w_count == LAST_IDX) w_state_nxt = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (word_ready) begin
          w_last_nxt  = r_src;
          w_word_done = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // A transfer on any port happens in a cycle where both valid and ready are
  // high; ready never depends on valid, so it is decided by state alone.
  assign req0_ready = (r_state == ST_COLLECT) && !r_src;
  assign req1_ready = (r_state == ST_COLLECT) &&  r_src;
  assign word_valid = (r_state == ST_EMIT);
  assign word_src   = r_src;
  assign grant      = (r_state == ST_IDLE) ? 2'b00 : {r_src, ~r_src};

  assign w_pack_clear = clear || w_word_done;

  byte_packer #(
    .BYTES_PER_WORD(BYTES_PER_WORD),
    .WORD_W        (WORD_W),
    .CNT_W         (CNT_W)
  ) u_packer (
    .clock    (clock),
    .clear    (w_pack_clear),
    .load_en  (w_load),
    .byte_in  (w_owner_data),
    .word_out (word_data),
    .count_out(w_count)
  );

endmodule

// File: tb/tb_byte_stream_arbiter.sv
// Randomized and directed bench for byte_stream_arbiter, checked cycle by cycle
// against a transaction-level reference model and a word scoreboard.
module tb_byte_stream_arbiter;

  localparam int BPW    = 4;
  localparam int WORD_W = 8 * BPW;

  logic              clock;
  logic              clear;
  logic              req0_valid, req1_valid;
  logic [7:0]        req0_data, req1_data;
  logic              req0_ready, req1_ready;
  logic              word_valid;
  logic [WORD_W-1:0] word_data;
  logic              word_src;
  logic              word_ready;
  logic [1:0]        grant;

  byte_stream_arbiter #(.BYTES_PER_WORD(BPW)) dut (
    .clock     (clock),
    .clear     (clear),
    .req0_valid(req0_valid),
    .req0_data (req0_data),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_data (req1_data),
    .req1_ready(req1_ready),
    .word_valid(word_valid),
    .word_data (word_data),
    .word_src  (word_src),
    .word_ready(word_ready),
    .grant     (grant)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- counters and scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  logic [WORD_W-1:0] exp_q[$];
  logic              exp_src_q[$];
  logic [WORD_W-1:0] got_q[$];
  logic              got_src_q[$];
  logic [7:0]        src0_q[$];
  logic [7:0]        src1_q[$];

  // ---------------- reference model ----------------
  bit         m_known = 0;
  int         m_owner = -1;   // -1 when no requester owns the output
  bit         m_emit  = 0;
  int         m_last  = 1;
  int         m_src   = 0;
  logic [7:0] m_bytes[$];

  bit hs0, hs1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic [63:0] pack_bytes(input logic [7:0] b[$]);
    logic [63:0] w = '0;
    foreach (b[i]) w = (w << 8) | 64'(b[i]);
    return w;
  endfunction

  // Called at a negedge with inputs already driven; checks, then advances one cycle.
  task automatic step();
    logic [1:0] eg;
    if (m_known) begin
      eg = (m_owner < 0) ? 2'b00 : ((m_owner == 0) ? 2'b01 : 2'b10);
      check("grant",      grant,      eg);
      check("req0_ready", req0_ready, !m_emit && m_owner == 0);
      check("req1_ready", req1_ready, !m_emit && m_owner == 1);
      check("word_valid", word_valid, m_emit);
      check("word_data",  word_data,  pack_bytes(m_bytes));
      check("word_src",   word_src,   m_src[0]);
      if (m_emit && word_ready && !clear) begin
        exp_q.push_back(WORD_W'(pack_bytes(m_bytes)));
        exp_src_q.push_back(m_owner[0]);
      end
    end
    if (word_valid === 1'b1 && word_ready && !clear) begin
      if (exp_q.size() == 0) check("sb_unexpected_word", 1, 0);
      else begin
        check("sb_word", word_data, exp_q.pop_front());
        check("sb_src",  word_src,  exp_src_q.pop_front());
      end
      got_q.push_back(word_data);
      got_src_q.push_back(word_src);
    end
    hs0 = !clear && req0_valid && (req0_ready === 1'b1);
    hs1 = !clear && req1_valid && (req1_ready === 1'b1);

    if (clear) begin
      m_known = 1; m_owner = -1; m_emit = 0; m_last = 1; m_src = 0;
      m_bytes.delete();
    end else if (!m_known) begin
      // nothing is known before the first clear
    end else if (m_owner < 0) begin
      if (req0_valid || req1_valid) begin
        m_owner = (req0_valid && req1_valid) ? 1 - m_last : (req0_valid ? 0 : 1);
        m_src   = m_owner;
      end
    end else if (!m_emit) begin
      if (m_owner == 0 && req0_valid) m_bytes.push_back(req0_data);
      if (m_owner == 1 && req1_valid) m_bytes.push_back(req1_data);
      if (m_bytes.size() == BPW) m_emit = 1;
    end else if (word_ready) begin
      m_last = m_owner; m_owner = -1; m_emit = 0;
      m_bytes.delete();
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    req0_valid = 0; req0_data = 8'h00;
    req1_valid = 0; req1_data = 8'h00;
    word_ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    clear = 1;
    step();
    step();
    clear = 0;
    exp_q.delete(); exp_src_q.delete();
    got_q.delete(); got_src_q.delete();
  endtask

  // Drains src0_q/src1_q through the DUT; bp > 0 holds word_ready low for bp EMIT cycles.
  task automatic run(input int budget, input int p_valid, input int p_ready,
                     input int bp, output int cycles);
    int emit_cnt = 0;
    bit done = 0;
    cycles = 0;
    while (!done && cycles < budget) begin
      req0_valid = (src0_q.size() > 0) && ($urandom_range(1, 100) <= p_valid);
      req0_data  = (src0_q.size() > 0) ? src0_q[0] : 8'($urandom);
      req1_valid = (src1_q.size() > 0) && ($urandom_range(1, 100) <= p_valid);
      req1_data  = (src1_q.size() > 0) ? src1_q[0] : 8'($urandom);
      if (bp > 0) begin
        if (word_valid === 1'b1) begin
          word_ready = (emit_cnt >= bp);
          emit_cnt   = word_ready ? 0 : emit_cnt + 1;
        end else word_ready = 0;
      end else word_ready = ($urandom_range(1, 100) <= p_ready);
      step();
      if (hs0) void'(src0_q.pop_front());
      if (hs1) void'(src1_q.pop_front());
      cycles++;
      done = (src0_q.size() == 0) && (src1_q.size() == 0) && (m_owner < 0);
    end
    check("run_done", done, 1);
    idle_inputs();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    logic [7:0] rb[$];
    clear = 1;
    idle_inputs();
    @(negedge clock);

    // Single requester, back-to-back bytes.
    do_reset();
    src0_q = '{8'h44, 8'h77, 8'h11, 8'h22};
    run(100, 100, 100, 0, cyc);
    check("single_word", got_q[0], 32'h44771122);
    check("single_src",  got_src_q[0], 0);
    check("single_cycles", cyc, 6);

    // Tie from clear: requester 0 first, then requester 1.
    do_reset();
    src0_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    src1_q = '{8'hB0, 8'hB1, 8'hB2, 8'hB3};
    run(100, 100, 100, 0, cyc);
    check("tie_count", got_q.size(), 2);
    check("tie_word0", got_q[0], 32'hA0A1A2A3);
    check("tie_src0",  got_src_q[0], 0);
    check("tie_word1", got_q[1], 32'hB0B1B2B3);
    check("tie_src1",  got_src_q[1], 1);

    // Gaps on requester 1: grant must stay locked.
    do_reset();
    req1_valid = 1; req1_data = 8'h01;
    step();
    step();
    check("gap_grant", grant, 2'b10);
    req1_valid = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("gap_grant", grant, 2'b10);
    end
    for (int i = 2; i <= 4; i++) begin
      req1_valid = 1; req1_data = 8'(i);
      step();
      check("gap_grant", grant, 2'b10);
    end
    req1_valid = 0; word_ready = 1;
    step();
    word_ready = 0;
    check("gap_word", got_q[0], 32'h01020304);
    check("gap_src",  got_src_q[0], 1);

    // Backpressure: word_ready low for 5 EMIT cycles.
    do_reset();
    for (int i = 0; i < BPW; i++) src0_q.push_back(8'($urandom));
    rb = src0_q;
    run(100, 100, 0, 5, cyc);
    check("bp_word", got_q[0], WORD_W'(pack_bytes(rb)));
    check("bp_cycles", cyc, 1 + BPW + 6);

    // Clear in the middle of a word discards the partial bytes.
    do_reset();
    req0_valid = 1; req0_data = 8'h44;
    step();
    step();
    req0_data = 8'h77;
    step();
    clear = 1;
    step();
    clear = 0; req0_valid = 0;
    check("clr_grant", grant, 2'b00);
    check("clr_word",  word_data, 0);
    src0_q = '{8'h11, 8'h12, 8'h13, 8'h14};
    run(100, 100, 100, 0, cyc);
    check("clr_count", got_q.size(), 1);
    check("clr_out",   got_q[0], 32'h11121314);

    // Random traffic on both requesters.
    do_reset();
    for (int r = 0; r < 6; r++) begin
      int n0 = $urandom_range(0, 3) * BPW;
      int n1 = $urandom_range(0, 3) * BPW;
      for (int i = 0; i < n0; i++) src0_q.push_back(8'($urandom));
      for (int i = 0; i < n1; i++) src1_q.push_back(8'($urandom));
      run(2000, $urandom_range(30, 100), $urandom_range(30, 100), 0, cyc);
    end
    check("sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
